// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair.
// One result bit per cycle, plus a single sign-fixup cycle before the write.
module mdu_iter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CNT_BITS = 6
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [5:0]       op_i,
  input  logic [WIDTH-1:0] param_1_i,
  input  logic [WIDTH-1:0] param_2_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam logic [5:0] FunctMthi = 6'h11;
  localparam logic [5:0] FunctMtlo = 6'h13;
  localparam logic [5:0] FunctMul  = 6'h18;
  localparam logic [5:0] FunctMulu = 6'h19;
  localparam logic [5:0] FunctDiv  = 6'h1a;
  localparam logic [5:0] FunctDivu = 6'h1b;

  typedef enum logic [1:0] {StIdle, StCalc, StFixup} state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                is_div_q, is_div_d;
  logic                res_neg_q, res_neg_d;
  logic                rem_neg_q, rem_neg_d;
  logic                done_q, done_d;
  logic                dz_q, dz_d;

  logic               op_mt, op_mul, op_div, op_signed, accept;
  logic               sign_1, sign_2;
  logic [WIDTH-1:0]   abs_1, abs_2;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, mul_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  // Request decode and operand conditioning
  always_comb begin
    op_mt     = (op_i == FunctMthi) || (op_i == FunctMtlo);
    op_mul    = (op_i == FunctMul) || (op_i == FunctMulu);
    op_div    = (op_i == FunctDiv) || (op_i == FunctDivu);
    op_signed = (op_i == FunctMul) || (op_i == FunctDiv);
    accept    = (state_q == StIdle) && start_i && !flush_i && (op_mt || op_mul || op_div);
    sign_1    = op_signed && param_1_i[WIDTH-1];
    sign_2    = op_signed && param_2_i[WIDTH-1];
    abs_1     = sign_1 ? -param_1_i : param_1_i;
    abs_2     = sign_2 ? -param_2_i : param_2_i;
  end

  // One iteration step of each datapath, plus the sign fixup of the final accumulator
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    // Shifted partial remainder needs WIDTH+1 bits; bit WIDTH of the difference is the borrow.
    div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, opnd_q};
    div_step = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    mul_res  = res_neg_q ? -acc_q : acc_q;
    quo_res  = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_res  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dz_d = 1'b0;
          if (op_mt) begin
            if (op_i == FunctMthi) begin
              hi_d = param_1_i;
            end else begin
              lo_d = param_1_i;
            end
          end else begin
            state_d   = StCalc;
            cnt_d     = '0;
            is_div_d  = op_div;
            res_neg_d = sign_1 ^ sign_2;
            rem_neg_d = sign_1;
            opnd_d    = op_div ? abs_2 : abs_1;
            acc_d     = {{WIDTH{1'b0}}, (op_div ? abs_1 : abs_2)};
          end
        end
      end
      StCalc: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          acc_d = is_div_q ? div_step : mul_step;
          cnt_d = cnt_q + CNT_BITS'(1);
          if (cnt_q == CNT_BITS'(WIDTH - 1)) begin
            state_d = StFixup;
          end
        end
      end
      StFixup: begin
        state_d = StIdle;
        if (!flush_i) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_res;
            lo_d = quo_res;
            // A zero divisor falls out of the restoring loop as quotient all-ones,
            // remainder |dividend|; the sign fixup then yields the required values.
            dz_d = (opnd_q == '0);
          end else begin
            {hi_d, lo_d} = mul_res;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    ready_o    = (state_q == StIdle);
    busy_o     = ~ready_o;
    done_o     = done_q;
    hi_o       = hi_q;
    lo_o       = lo_q;
    div_zero_o = dz_q;
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomised and directed bench for mdu_iter; results are compared against a
// plain-arithmetic HI/LO model.
module tb_mdu_iter;

  localparam int W = 32;
  localparam logic [5:0] OpMthi = 6'h11;
  localparam logic [5:0] OpMtlo = 6'h13;
  localparam logic [5:0] OpMul  = 6'h18;
  localparam logic [5:0] OpMulu = 6'h19;
  localparam logic [5:0] OpDiv  = 6'h1a;
  localparam logic [5:0] OpDivu = 6'h1b;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, flush;
  logic [5:0]   op;
  logic [W-1:0] p1, p2;
  logic         ready, busy, done, dz;
  logic [W-1:0] hi, lo;

  logic       start8, flush8;
  logic [5:0] op8;
  logic [7:0] a8, b8, hi8, lo8;
  logic       ready8, busy8, done8, dz8;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W), .CNT_BITS(6)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .op_i(op), .param_1_i(p1),
    .param_2_i(p2), .flush_i(flush), .ready_o(ready), .busy_o(busy), .done_o(done),
    .hi_o(hi), .lo_o(lo), .div_zero_o(dz)
  );

  mdu_iter #(.WIDTH(8), .CNT_BITS(4)) dut8 (
    .clock_i(clk), .reset_i(rst), .start_i(start8), .op_i(op8), .param_1_i(a8),
    .param_2_i(b8), .flush_i(flush8), .ready_o(ready8), .busy_o(busy8), .done_o(done8),
    .hi_o(hi8), .lo_o(lo8), .div_zero_o(dz8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Architectural model
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic model_op(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb, q, r;
    logic [63:0]     p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    m_dz = 1'b0;
    case (o)
      OpMthi: m_hi = a;
      OpMtlo: m_lo = a;
      OpMul: begin
        p = 64'(sa * sb);
        {m_hi, m_lo} = p;
      end
      OpMulu: begin
        p = 64'(a) * 64'(b);
        {m_hi, m_lo} = p;
      end
      OpDivu: begin
        if (b == '0) begin
          m_hi = a; m_lo = '1; m_dz = 1'b1;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      OpDiv: begin
        if (b == '0) begin
          m_hi = a; m_lo = a[W-1] ? W'(1) : '1; m_dz = 1'b1;
        end else begin
          q = sa / sb; r = sa % sb;
          m_lo = q[W-1:0]; m_hi = r[W-1:0];
        end
      end
      default: ;
    endcase
  endtask

  // Presents a request for one cycle; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; p1 = a; p2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag, input bit poke);
    int k;
    bit busy_ok;
    start_op(o, a, b);
    model_op(o, a, b);
    if (o == OpMthi || o == OpMtlo) begin
      check({tag, ".mt_ready"}, 64'(ready), 64'(1));
      check({tag, ".mt_done"}, 64'(done), 64'(0));
    end else begin
      k = 0;
      busy_ok = 1'b1;
      while (!done && k < 200) begin
        if (!busy) busy_ok = 1'b0;
        @(negedge clk);
        k++;
        if (poke && k == 5) begin
          start = 1'b1; op = OpMthi; p1 = 32'h0000_dead;
        end
        if (poke && k == 6) start = 1'b0;
      end
      check({tag, ".latency"}, 64'(k), 64'(W + 1));
      check({tag, ".busy"}, 64'(busy_ok), 64'(1));
      check({tag, ".ready"}, 64'(ready), 64'(1));
      check({tag, ".dz"}, 64'(dz), 64'(m_dz));
    end
    check({tag, ".hi"}, 64'(hi), 64'(m_hi));
    check({tag, ".lo"}, 64'(lo), 64'(m_lo));
    @(negedge clk);
    check({tag, ".done_low"}, 64'(done), 64'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  logic [5:0] ops [6] = '{OpMthi, OpMtlo, OpMul, OpMulu, OpDiv, OpDivu};

  initial begin
    int k;
    bit seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; p1 = '0; p2 = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    #2;
    check("rst.ready", 64'(ready), 64'(1));
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.hi", 64'(hi), 64'(0));
    check("rst.lo", 64'(lo), 64'(0));
    check("rst.dz", 64'(dz), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(OpMulu, 32'hffff_ffff, 32'h2, "mulu", 1'b0);
    check("mulu.hi_const", 64'(hi), 64'h1);
    check("mulu.lo_const", 64'(lo), 64'hffff_fffe);

    run_op(OpDiv, 32'hffff_fff9, 32'h2, "div_m7", 1'b0);
    check("div_m7.lo_const", 64'(lo), 64'hffff_fffd);
    check("div_m7.hi_const", 64'(hi), 64'hffff_ffff);
    run_op(OpDiv, 32'h8000_0000, 32'hffff_ffff, "div_ovf", 1'b0);
    check("div_ovf.lo_const", 64'(lo), 64'h8000_0000);
    check("div_ovf.hi_const", 64'(hi), 64'h0);

    run_op(OpDivu, 32'h1234, 32'h0, "divu0", 1'b0);
    check("divu0.dz_const", 64'(dz), 64'h1);
    run_op(OpDiv, 32'hffff_fff0, 32'h0, "div0_neg", 1'b0);
    check("div0_neg.lo_const", 64'(lo), 64'h1);
    run_op(OpMulu, 32'h3, 32'h4, "dz_clear", 1'b0);
    check("dz_clear.dz_const", 64'(dz), 64'h0);

    // MTHI and MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1; op = OpMthi; p1 = 32'hcafe;
    @(negedge clk);
    check("mt.ready_mid", 64'(ready), 64'(1));
    op = OpMtlo; p1 = 32'hbeef;
    @(negedge clk);
    start = 1'b0;
    m_hi = 32'hcafe; m_lo = 32'hbeef;
    check("mt.hi", 64'(hi), 64'hcafe);
    check("mt.lo", 64'(lo), 64'hbeef);
    check("mt.ready", 64'(ready), 64'(1));
    check("mt.done", 64'(done), 64'(0));

    // Flush during CALC: the flushing edge is edge 10 after accept
    start_op(OpMul, 32'h1234_5678, 32'h9abc_def0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc.ready", 64'(ready), 64'(1));
    check("flush_calc.hi", 64'(hi), 64'(m_hi));
    check("flush_calc.lo", 64'(lo), 64'(m_lo));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("flush_calc.no_done", 64'(seen), 64'(0));

    // Flush during FIXUP (divide by zero must not raise the flag either)
    start_op(OpDivu, 32'h55, 32'h0);
    m_dz = 1'b0;
    repeat (W) @(negedge clk);
    check("flush_fix.in_fixup", 64'(busy), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_fix.ready", 64'(ready), 64'(1));
    check("flush_fix.done", 64'(done), 64'(0));
    check("flush_fix.hi", 64'(hi), 64'(m_hi));
    check("flush_fix.lo", 64'(lo), 64'(m_lo));
    check("flush_fix.dz", 64'(dz), 64'(0));

    // Flush while idle blocks a same-edge start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OpMthi; p1 = 32'h1357_9bdf;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_idle.hi", 64'(hi), 64'(m_hi));

    // Unknown funct code is never accepted
    @(negedge clk);
    start = 1'b1; op = 6'h20; p1 = 32'h2468_ace0; p2 = 32'h3;
    @(negedge clk);
    start = 1'b0;
    check("badop.ready", 64'(ready), 64'(1));
    check("badop.hi", 64'(hi), 64'(m_hi));
    check("badop.lo", 64'(lo), 64'(m_lo));

    // Start while busy is ignored
    run_op(OpMul, 32'hffff_fffd, 32'h0000_0007, "busy_poke", 1'b1);

    // Reset in the middle of CALC
    run_op(OpDivu, 32'h5, 32'h0, "pre_rst", 1'b0);
    start_op(OpMul, 32'h7, 32'h9);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.hi", 64'(hi), 64'(0));
    check("midrst.lo", 64'(lo), 64'(0));
    check("midrst.ready", 64'(ready), 64'(1));
    check("midrst.busy", 64'(busy), 64'(0));
    check("midrst.dz", 64'(dz), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;

    for (int i = 0; i < 60; i++) begin
      run_op(ops[$urandom_range(0, 5)], pick(), pick(), $sformatf("rnd%0d", i), 1'b0);
    end

    // WIDTH=8 instance, with a back-to-back start on the done cycle
    @(negedge clk);
    start8 = 1'b1; op8 = OpMul; a8 = 8'h80; b8 = 8'hff;
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (!done8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("w8.latency", 64'(k), 64'(9));
    check("w8.prod", 64'({hi8, lo8}), 64'h0080);
    check("w8.ready", 64'(ready8), 64'(1));
    start8 = 1'b1; op8 = OpMulu; a8 = 8'd3; b8 = 8'd5;
    @(negedge clk);
    start8 = 1'b0;
    check("w8.b2b_accept", 64'(busy8), 64'(1));
    k = 0;
    while (!done8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("w8.b2b_latency", 64'(k), 64'(9));
    check("w8.b2b_prod", 64'({hi8, lo8}), 64'd15);
    check("w8.dz", 64'(dz8), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
